// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Runtime-programmable serial pattern detector. A legal start arms the
//   block (HUNT) with a captured pattern of 1..PAT_W bits; every qualified
//   serial bit is shifted into a history register and compared against the
//   pattern. Each occurrence produces a one-cycle z pulse and bumps a
//   saturating match counter. Overlapping or non-overlapping matching is
//   selected at start time.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start/stop : arm (captures pattern/len/overlap) / disarm pulses
//   pattern    : pattern bits, bit [len-1] first on the wire, bit [0] last
//   len        : active pattern length (1..PAT_W legal)
//   overlap    : 1 = overlapping matches, 0 = non-overlapping
//   x_valid, x : qualified serial data
//   z          : one-cycle match pulse (registered)
//   match_cnt  : saturating matches since last legal start
//   armed      : high while hunting
//   err        : one-cycle pulse after a rejected start
module seq_detector_param #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  input  logic             x_valid,
  input  logic             x,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed,
  output logic             err
);

  typedef enum logic {IDLE, HUNT} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [PAT_W-2:0] hist;
  logic [LEN_W-1:0] fill;

  logic             len_ok;
  logic             sample;
  logic             fill_ok;
  logic             hit;
  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] mask;
  logic [LEN_W:0]   fill_p1;

  always_comb begin
    len_ok  = (len != '0) && (len <= MAX_LEN);
    // Bits arriving in a start or stop cycle are never sampled.
    sample  = (state == HUNT) && x_valid && !start && !stop;
    window  = {hist, x};
    mask    = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
    // fill >= len_q-1, written without subtraction so len_q never underflows
    fill_p1 = {1'b0, fill} + (LEN_W + 1)'(1);
    fill_ok = fill_p1 >= {1'b0, len_q};
    hit     = sample && fill_ok && ((window & mask) == (pat_q & mask));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      hist      <= '0;
      fill      <= '0;
      z         <= 1'b0;
      match_cnt <= '0;
      armed     <= 1'b0;
      err       <= 1'b0;
    end else begin
      z   <= hit;
      err <= 1'b0;
      if (stop) begin
        state <= IDLE;
        armed <= 1'b0;
      end else if (start) begin
        if (len_ok) begin
          state     <= HUNT;
          armed     <= 1'b1;
          pat_q     <= pattern;
          len_q     <= len;
          ovl_q     <= overlap;
          hist      <= '0;
          fill      <= '0;
          match_cnt <= '0;
        end else begin
          err <= 1'b1;
        end
      end else if (sample) begin
        hist <= window[PAT_W-2:0];
        if (hit && !ovl_q) begin
          fill <= '0;
        end else if (fill < len_q) begin
          fill <= fill + LEN_W'(1);
        end
        if (hit && (match_cnt != '1)) begin
          match_cnt <= match_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
